// File: rtl/hilo_unit_if.sv
// Pipeline-side port bundle of the HI/LO controller: the EX-stage instruction
// going in, and the stall request plus move-from result coming back.
interface hilo_unit_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output op_valid, op, rs_data, rt_data,
        input  stall, rd_data, rd_valid
    );

    modport slave (
        input  op_valid, op, rs_data, rt_data,
        output stall, rd_data, rd_valid
    );
endinterface

// File: rtl/hilo_unit.sv
// EX-stage HI/LO controller: launches the external multi-cycle multiplier,
// captures its product into HI/LO after a fixed latency and stalls HI/LO users meanwhile.
module hilo_unit #(
    parameter int MULT_LATENCY = 32
) (
    input  logic        clk,
    input  logic        rst,
    hilo_unit_if.slave  pipe,
    output logic        mul_start,
    output logic        mul_is_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_s,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MFHI  = 3'd2;
    localparam logic [2:0] OP_MFLO  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic       accept, capture, wr_hi, wr_lo, hilo_op;

    assign hilo_op = pipe.op_valid && (pipe.op <= OP_MTLO);

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        capture       = 1'b0;
        wr_hi         = 1'b0;
        wr_lo         = 1'b0;
        pipe.stall    = 1'b0;
        pipe.rd_valid = 1'b0;
        pipe.rd_data  = 32'd0;
        case (state)
            IDLE: begin
                if (pipe.op_valid) begin
                    case (pipe.op)
                        OP_MULT, OP_MULTU: begin
                            accept    = 1'b1;
                            state_nxt = LAUNCH;
                        end
                        OP_MFHI: begin
                            pipe.rd_valid = 1'b1;
                            pipe.rd_data  = hi;
                        end
                        OP_MFLO: begin
                            pipe.rd_valid = 1'b1;
                            pipe.rd_data  = lo;
                        end
                        OP_MTHI: wr_hi = 1'b1;
                        OP_MTLO: wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            LAUNCH: begin
                pipe.stall = hilo_op;
                state_nxt  = BUSY;
            end
            BUSY: begin
                pipe.stall = hilo_op;
                // mul_s is valid on the edge that ends the cycle where cnt reads 1
                if (cnt == 8'd1) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            mul_start     <= 1'b0;
            mul_is_signed <= 1'b0;
            mul_a         <= 32'd0;
            mul_b         <= 32'd0;
            hi            <= 32'd0;
            lo            <= 32'd0;
        end else begin
            state     <= state_nxt;
            mul_start <= accept;
            if (accept) begin
                mul_a         <= pipe.rs_data;
                mul_b         <= pipe.rt_data;
                mul_is_signed <= (pipe.op == OP_MULT);
            end
            if (state == LAUNCH)
                cnt <= 8'(MULT_LATENCY);
            else if (state == BUSY)
                cnt <= cnt - 8'd1;
            if (capture) begin
                hi <= mul_s[63:32];
                lo <= mul_s[31:0];
            end
            if (wr_hi) hi <= pipe.rs_data;
            if (wr_lo) lo <= pipe.rs_data;
        end
    end
endmodule

// File: doc/hilo_unit.md
# hilo_unit

Multiply/HI-LO controller in the EX stage of the 5-stage MIPS pipeline, sitting directly upstream of the multi-cycle `mult` unit. It decodes MULT/MULTU/MFHI/MFLO/MTHI/MTLO from the pipeline and drives `mult`'s start, signedness and operands. It waits a fixed latency, captures the 64-bit product into the architectural HI/LO registers, and stalls the pipeline on any HI/LO access while a multiply is in flight.

## Interface
- `MULT_LATENCY`, default 32: cycles from the edge at which `mult` samples `start`=1 to the edge at which `s` is valid (range 1..255).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `op_valid` in 1: EX stage holds a HI/LO-class instruction.
- `op` in 3: 0 MULT, 1 MULTU, 2 MFHI, 3 MFLO, 4 MTHI, 5 MTLO; 6 and 7 reserved.
- `rs_data` in 32: rs operand (multiplicand; MTHI/MTLO source).
- `rt_data` in 32: rt operand (multiplier).
- `stall` out 1: hold the pipeline; the instruction must be re-presented unchanged.
- `rd_data` out 32: MFHI/MFLO result.
- `rd_valid` out 1: `rd_data` is valid this cycle.
- `mul_start` out 1: to `mult.start`.
- `mul_is_signed` out 1: to `mult.is_signed`.
- `mul_a` out 32: to `mult.a`.
- `mul_b` out 32: to `mult.b`.
- `mul_s` in 64: from `mult.s`.
- `hi` out 32: architectural HI register.
- `lo` out 32: architectural LO register.

## Operation
- **FSM states.** IDLE, LAUNCH, BUSY; 8-bit down-counter `cnt`.
- **IDLE, MULT/MULTU.** On `op_valid` with op 0/1, at the edge:
  - latch `mul_a`=`rs_data`, `mul_b`=`rt_data`, `mul_is_signed`=(op==0);
  - set `mul_start`=1 and go to LAUNCH.
  - No stall in this cycle: the instruction is accepted.
- **LAUNCH.** Lasts exactly one cycle. `mul_start`=1, `cnt` loads `MULT_LATENCY`, next state BUSY.
- **BUSY.** `mul_start`=0. `cnt` decrements each edge.
  - At the edge where `cnt`==1: `{hi,lo}` <= `mul_s`, next state IDLE.
  - `mul_a`, `mul_b` and `mul_is_signed` are held constant throughout LAUNCH and BUSY.
- **MFHI/MFLO in IDLE.** Combinational: `rd_data`=`hi`/`lo` and `rd_valid`=1 in the same cycle.
- **MTHI/MTLO in IDLE.** `hi`/`lo` <= `rs_data` at the edge; the other register is unchanged.
- **Stall.** `stall` = `op_valid` & (state != IDLE) & (op <= 5).
  - Applies to every HI/LO-class op, including a new MULT.
  - `rd_valid`=0 while stalled.
  - MTHI/MTLO are not written while stalled.
- **Idle outputs.** In IDLE with no MFHI/MFLO: `rd_data`=0, `rd_valid`=0.
- **Reserved ops 6/7.** Ignored: no stall, no state change, `rd_valid`=0.
- **Reset values.** `hi`=`lo`=0, `mul_start`=0, `mul_is_signed`=0, `mul_a`=`mul_b`=0, `cnt`=0, state IDLE. `stall` and `rd_valid` are combinational and therefore 0 while `op_valid`=0.
- **Reset during LAUNCH/BUSY.** The in-flight product is discarded and HI/LO are cleared. `mult` has no reset, so its next `start` pulse re-initialises it.

## Timing
- **Accept to HI/LO update.** Accept edge E0 → `mul_start` high in cycle E0..E1 → `mult` samples start at E1 → HI/LO written at edge E(1+`MULT_LATENCY`). With the default, new HI/LO is visible 33 cycles after accept.
- **Stall window.** `stall` is asserted for a pending HI/LO op in every cycle from E0+ through the cycle ending at E(1+`MULT_LATENCY`).
  - A waiting MFHI/MFLO gets `rd_valid`=1 in the first cycle after the capture edge.
  - That read returns the new product.
- **Back-to-back multiplies.** A second MULT is accepted in that same first cycle after capture, so the minimum spacing is `MULT_LATENCY`+2 cycles.
- **`mul_start` width.** Exactly one cycle per accepted MULT/MULTU; never asserted twice for one instruction.

## Test plan
- **MULTU 5×7.** MULTU, rs=5, rt=7, `op_valid` for 1 cycle → `mul_start` pulse of 1 cycle with `mul_is_signed`=0; `hi`=0, `lo`=35 exactly 33 edges after accept; `stall`=0 in the accept cycle.
- **Signed MULT.** MULT, rs=0xFFFFFFFF, rt=2 → `mul_is_signed`=1; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
- **MFHI while busy.** Issue MFHI 3 cycles after accepting MULTU 0x10000×0x10000 → `stall`=1 until capture; next cycle `rd_valid`=1, `rd_data`=0x00000001.
- **MTHI/MTLO then reads.** MTHI rs=0xDEADBEEF, then MTLO rs=0x12345678, then MFHI, then MFLO → `rd_data` 0xDEADBEEF then 0x12345678, `rd_valid`=1, zero stalls.
- **Reset mid-multiply.** Assert `rst` 10 cycles into BUSY → next cycle state IDLE, `hi`=`lo`=0, `mul_start`=0; a new MULTU 3×4 afterwards gives `lo`=12 on schedule.
- **Back-to-back MULTs and reserved ops.** Hold MULT 2×3 then MULT 4×5, op 6 interleaved → op 6 never stalls; the second MULT is accepted 34 cycles after the first; final `lo`=20, `hi`=0.
